// File: rtl/mem_ctrl_pkg.sv
// Shared widths, FSM state encoding and load/store length encoding for mem_ctrl.
package mem_ctrl_pkg;

    localparam int MemAddrBus = 32;
    localparam int MemDataBus = 32;
    localparam int RamDataBus = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_IF_RD = 3'd1,
        ST_LS_RD = 3'd2,
        ST_LS_WR = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    // ls_len carries byte count minus one
    typedef enum logic [1:0] {
        LEN_BYTE   = 2'd0,
        LEN_HALF   = 2'd1,
        LEN_TRIPLE = 2'd2,
        LEN_WORD   = 2'd3
    } ls_len_e;

    // Which requester owns the transfer in flight (selects the ready pulse)
    typedef enum logic [1:0] {
        OP_FETCH = 2'd0,
        OP_LOAD  = 2'd1,
        OP_STORE = 2'd2
    } op_e;

    function automatic logic [2:0] xfer_bytes(input logic [1:0] len);
        return {1'b0, len} + 3'd1;
    endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: arbitrates instruction fetch and load/store
// requests onto an 8-bit RAM port with one-cycle read latency.
// Optional MEM_CTRL_RR_EN: round-robin between fetch and load/store on a
// same-cycle collision; without it load/store always wins.
module mem_ctrl
    import mem_ctrl_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  discard,
    input  logic                  if_read,
    input  logic [MemAddrBus-1:0] if_addr,
    output logic                  if_busy,
    output logic                  if_ready,
    output logic [MemDataBus-1:0] if_data,
    input  logic                  ls_read,
    input  logic                  ls_write,
    input  logic [MemAddrBus-1:0] ls_addr,
    input  logic [1:0]            ls_len,
    input  logic [MemDataBus-1:0] ls_wdata,
    output logic                  ls_busy,
    output logic                  ls_ready,
    output logic [MemDataBus-1:0] ls_rdata,
    output logic [MemAddrBus-1:0] mem_addr,
    output logic                  mem_wr,
    output logic [RamDataBus-1:0] mem_dout,
    input  logic [RamDataBus-1:0] mem_din
);

    state_e                state, state_n;
    op_e                   op, op_n;
    logic [2:0]            cnt;
    logic [2:0]            nbytes, nbytes_n;
    logic [MemAddrBus-1:0] base;
    logic [MemDataBus-1:0] wdata_q;
    logic [MemDataBus-1:0] asm_q, asm_n;
    logic                  if_req, ls_req, take_if;

    // A fetch is not eligible while discard is high
    assign if_req = if_read & ~discard;
    assign ls_req = ls_read | ls_write;

`ifdef MEM_CTRL_RR_EN
    logic rr_if_turn;
    logic collide;

    assign collide = if_req & ls_req;
    assign take_if = if_req & (~ls_req | rr_if_turn);

    // Priority pointer only moves when a real collision is arbitrated
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            rr_if_turn <= 1'b0;
        else if (state == ST_IDLE && collide)
            rr_if_turn <= ~rr_if_turn;
    end
`else
    assign take_if = if_req & ~ls_req;
`endif

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            state <= ST_IDLE;
        else
            state <= state_n;
    end

    // Next state: accept only in IDLE, store beats write, DONE is a one-cycle turnaround
    always_comb begin
        state_n  = state;
        op_n     = op;
        nbytes_n = nbytes;
        case (state)
            ST_IDLE: begin
                if (take_if) begin
                    state_n  = ST_IF_RD;
                    op_n     = OP_FETCH;
                    nbytes_n = xfer_bytes(LEN_WORD);
                end else if (ls_write) begin
                    state_n  = ST_LS_WR;
                    op_n     = OP_STORE;
                    nbytes_n = xfer_bytes(ls_len);
                end else if (ls_read) begin
                    state_n  = ST_LS_RD;
                    op_n     = OP_LOAD;
                    nbytes_n = xfer_bytes(ls_len);
                end
            end
            ST_IF_RD: begin
                if (discard)
                    state_n = ST_IDLE;
                else if (cnt == nbytes)
                    state_n = ST_DONE;
            end
            ST_LS_RD: begin
                if (cnt == nbytes)
                    state_n = ST_DONE;
            end
            ST_LS_WR: begin
                if (cnt == nbytes - 3'd1)
                    state_n = ST_DONE;
            end
            ST_DONE:  state_n = ST_IDLE;
            default:  state_n = ST_IDLE;
        endcase
    end

    // Merge the byte arriving this cycle (address was issued at cnt-1)
    always_comb begin
        asm_n = asm_q;
        case (cnt)
            3'd1:    asm_n[7:0]   = mem_din;
            3'd2:    asm_n[15:8]  = mem_din;
            3'd3:    asm_n[23:16] = mem_din;
            3'd4:    asm_n[31:24] = mem_din;
            default: ;
        endcase
    end

    // Transfer bookkeeping: latch request on accept, step the byte counter
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            op      <= OP_FETCH;
            nbytes  <= 3'd0;
            cnt     <= 3'd0;
            base    <= '0;
            wdata_q <= '0;
            asm_q   <= '0;
        end else begin
            op     <= op_n;
            nbytes <= nbytes_n;
            if (state == ST_IDLE) begin
                cnt   <= 3'd0;
                asm_q <= '0;
                if (state_n != ST_IDLE) begin
                    base    <= take_if ? if_addr : ls_addr;
                    wdata_q <= ls_wdata;
                end
            end else begin
                cnt <= cnt + 3'd1;
                if (state == ST_IF_RD || state == ST_LS_RD)
                    asm_q <= asm_n;
            end
        end
    end

    // Result registers update only on a completed read, so they hold between pulses
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            if_data  <= '0;
            ls_rdata <= '0;
        end else if (state_n == ST_DONE) begin
            if (state == ST_IF_RD)
                if_data <= asm_n;
            else if (state == ST_LS_RD)
                ls_rdata <= asm_n;
        end
    end

    // RAM port: address/strobe only while a byte is being issued, zero otherwise
    always_comb begin
        mem_addr = '0;
        mem_wr   = 1'b0;
        mem_dout = '0;
        case (state)
            ST_IF_RD, ST_LS_RD: begin
                if (cnt != nbytes)
                    mem_addr = base + {{(MemAddrBus-3){1'b0}}, cnt};
            end
            ST_LS_WR: begin
                mem_addr = base + {{(MemAddrBus-3){1'b0}}, cnt};
                mem_wr   = 1'b1;
                case (cnt)
                    3'd0:    mem_dout = wdata_q[7:0];
                    3'd1:    mem_dout = wdata_q[15:8];
                    3'd2:    mem_dout = wdata_q[23:16];
                    default: mem_dout = wdata_q[31:24];
                endcase
            end
            default: ;
        endcase
    end

    assign if_busy  = (state != ST_IDLE);
    assign ls_busy  = (state != ST_IDLE);
    assign if_ready = (state == ST_DONE) && (op == OP_FETCH);
    assign ls_ready = (state == ST_DONE) && (op != OP_FETCH);

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 Parameters: none; widths come from shared defines (MemAddrBus 32b, MemDataBus 32b, RamDataBus 8b).
REQ-002 clock  in  1  single clock, rising edge.
REQ-003 reset  in  1  asynchronous, active-low; low clears all state immediately.
REQ-004 discard  in  1  pipeline flush; aborts in-flight instruction fetch.
REQ-005 if_read  in  1  instruction-fetch request (level, 4-byte read).
REQ-006 if_addr  in  32  fetch byte address.
REQ-007 if_busy  out  1  controller not idle; fetch request not acceptable.
REQ-008 if_ready  out  1  one-cycle pulse: if_data valid.
REQ-009 if_data  out  32  fetched word, little-endian.
REQ-010 ls_read / ls_write  in  1 each  load/store request (level).
REQ-011 ls_addr  in  32  load/store byte address.
REQ-012 ls_len  in  2  byte count minus 1 (0=byte, 1=half, 3=word).
REQ-013 ls_wdata  in  32  store data; low (ls_len+1) bytes used.
REQ-014 ls_busy / ls_ready / ls_rdata  out  1/1/32  as if_* for load/store; ready also pulses on store completion.
REQ-015 mem_addr  out  32  RAM byte address; mem_wr  out  1  write strobe; mem_dout  out  8  write byte; mem_din  in  8  read byte, valid the cycle after its address.

Function
REQ-016 FSM states: IDLE, IF_RD, LS_RD, LS_WR, DONE; busy outputs high in every state except IDLE.
REQ-017 Requests are sampled only in IDLE; requests seen in DONE are ignored (one-cycle turnaround), DONE returns to IDLE.
REQ-018 Grant on accept edge: latch base address, N = 4 (fetch) or ls_len+1 (load/store), byte counter = 0.
REQ-019 Read: cycles 1..N after accept drive mem_addr = base+k (k=0..N-1), mem_wr=0; capture mem_din into byte k at the following edge.
REQ-020 Read completion: ready pulses one cycle at cycle N+2 (word read: cycle 6; byte: cycle 3) with assembled data; unfilled upper bytes zero.
REQ-021 Write: cycles 1..N drive mem_addr = base+k, mem_wr=1, mem_dout = ls_wdata byte k; ls_ready pulses in cycle N+1 (word: 5).
REQ-022 Address increment wraps modulo 2^32 (0xFFFFFFFF+1 = 0x00000000).
REQ-023 ls_read and ls_write both high: write taken, read ignored.
REQ-024 discard high in IF_RD: next edge returns to IDLE, no if_ready pulse, partial data dropped; discard in IDLE with if_read high: fetch not accepted that cycle.
REQ-025 discard never affects LS_RD/LS_WR; accepted stores always complete.
REQ-026 In IDLE/DONE: mem_addr=0, mem_wr=0, mem_dout=0.
REQ-027 if_data/ls_rdata hold last value between pulses; ready is never high outside its DONE cycle.

Reset
REQ-028 reset low: state=IDLE, all outputs 0, counters 0, arbitration pointer to load/store; any in-progress transfer abandoned with no ready pulse.
REQ-029 First request accepted at the first rising edge after reset deasserts.

Configuration
REQ-030 Macro MEM_CTRL_RR_EN defined: simultaneous if_read and ls request in IDLE granted round-robin (the one not granted last); undefined: load/store always wins.

Structure
REQ-031 define.v holds bus widths, RamDataBus, FSM state encodings and ls_len encoding.
REQ-032 Single module, no sub-modules; byte assembly inline.

Verification
REQ-033 ls_write len=3 addr 0x100 data 0xDDCCBBAA -> mem_wr cycles 1-4, bytes AA,BB,CC,DD at 0x100-0x103, ls_ready cycle 5.
REQ-034 if_read addr 0x200, RAM holds 13,00,00,93 -> if_ready cycle 6, if_data 0x93000013.
REQ-035 if_read and ls_read(len=0, addr 0x10, byte 0x7F) same cycle, no macro -> load first (ls_rdata 0x0000007F cycle 3), fetch accepted cycle 4; with MEM_CTRL_RR_EN, second collision grants fetch.
REQ-036 discard at cycle 3 of fetch -> no if_ready, IDLE cycle 4, new fetch accepted.
REQ-037 ls_read len=1 at 0xFFFFFFFF -> mem_addr 0xFFFFFFFF then 0x00000000.
REQ-038 reset low mid-store cycle 2 -> mem_wr=0 immediately, no ls_ready, IDLE after release.
